// File: rtl/ddr4_cmd_tracker_pkg.sv
// Shared types and constants for the DDR4 command-bus tracker: command codes,
// error bit positions and the positions of the command bits on the address bus.
package ddr4_cmd_tracker_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    MRS  = 4'd1,
    REF  = 4'd2,
    PRE  = 4'd3,
    PREA = 4'd4,
    ACT  = 4'd5,
    WR   = 4'd6,
    WRA  = 4'd7,
    RD   = 4'd8,
    RDA  = 4'd9,
    ZQC  = 4'd10,
    RFU  = 4'd11
  } ddr4_cmd_e;

  localparam int ERR_ACT_OPEN = 0;
  localparam int ERR_CLOSED   = 1;
  localparam int ERR_REF_OPEN = 2;
  localparam int ERR_MULTI_CS = 3;
  localparam int ERR_TRCD     = 4;
  localparam int ERR_TRP      = 5;
  localparam int ERR_W        = 6;

  localparam int A_RAS = 16;
  localparam int A_CAS = 15;
  localparam int A_WE  = 14;
  localparam int A_AP  = 10;
  localparam int A_BC  = 12;

  function automatic logic is_rdwr(input ddr4_cmd_e c);
    return (c == WR) || (c == WRA) || (c == RD) || (c == RDA);
  endfunction

endpackage

// File: rtl/ddr4_bank_tracker.sv
// State of one DDR4 bank: open flag, the row that is open, and (with
// DDR4_CMD_TRACKER_TIMING_EN) a saturating timer since the last ACT/PRE.
module ddr4_bank_tracker #(
  parameter int AWIDTH = 17,
  parameter int TRCD   = 16,
  parameter int TRP    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_act,
  input  logic              i_pre,
  input  logic              i_ap_close,
  input  logic [AWIDTH-1:0] i_row,
  output logic              o_open,
  output logic [AWIDTH-1:0] o_row,
  output logic              o_trcd_ok,
  output logic              o_trp_ok
);

  logic              r_open;
  logic [AWIDTH-1:0] r_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_open <= 1'b0;
      r_row  <= '0;
    end else if (i_act) begin
      r_open <= 1'b1;
      r_row  <= i_row;
    end else if (i_pre || i_ap_close) begin
      r_open <= 1'b0;
    end
  end

  assign o_open = r_open;
  assign o_row  = r_row;

`ifdef DDR4_CMD_TRACKER_TIMING_EN
  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int TW   = $clog2(TMAX + 2);

  // Reload to 1 so the value seen at a later command edge equals the clk gap.
  logic [TW-1:0] r_tmr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmr <= '1;
    end else if (i_act || i_pre) begin
      r_tmr <= TW'(1);
    end else if (r_tmr != '1) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  assign o_trcd_ok = (r_tmr >= TW'(TRCD));
  assign o_trp_ok  = (r_tmr >= TW'(TRP));
`else
  assign o_trcd_ok = 1'b1;
  assign o_trp_ok  = 1'b1;
`endif

endmodule

// File: rtl/ddr4_cmd_tracker.sv
// Passive DDR4 command-bus monitor: decode, per-bank state, sticky errors and
// saturating counters. Define DDR4_CMD_TRACKER_TIMING_EN to build tRCD/tRP checks.
module ddr4_cmd_tracker
  import ddr4_cmd_tracker_pkg::*;
#(
  parameter int AWIDTH = 17,
  parameter int RWIDTH = 1,
  parameter int BWIDTH = 2,
  parameter int GWIDTH = 2,
  parameter int CWIDTH = 32,
  parameter int TRCD   = 16,
  parameter int TRP    = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [RWIDTH-1:0]                         ddr4_cke,
  input  logic [RWIDTH-1:0]                         ddr4_cs_n,
  input  logic                                      ddr4_act_n,
  input  logic [GWIDTH-1:0]                         ddr4_bg,
  input  logic [BWIDTH-1:0]                         ddr4_ba,
  input  logic [AWIDTH-1:0]                         ddr4_addr,
  input  logic                                      clr,
  output logic                                      cmd_vld,
  output logic [3:0]                                cmd_type,
  output logic [((RWIDTH > 1) ? $clog2(RWIDTH) : 1)-1:0] cmd_rank,
  output logic [GWIDTH+BWIDTH-1:0]                  cmd_bank,
  output logic [AWIDTH-1:0]                         cmd_row,
  output logic [9:0]                                cmd_col,
  output logic [(RWIDTH<<(GWIDTH+BWIDTH))-1:0]      bank_open,
  output logic [5:0]                                err,
  output logic [CWIDTH-1:0]                         act_cnt,
  output logic [CWIDTH-1:0]                         rd_cnt,
  output logic [CWIDTH-1:0]                         wr_cnt
);

  localparam int GB  = GWIDTH + BWIDTH;
  localparam int NBR = 1 << GB;
  localparam int NB  = RWIDTH * NBR;
  localparam int RIW = (RWIDTH > 1) ? $clog2(RWIDTH) : 1;
  localparam int IW  = $clog2(NB);
`ifdef DDR4_CMD_TRACKER_TIMING_EN
  localparam bit TIMING = 1'b1;
`else
  localparam bit TIMING = 1'b0;
`endif

  logic [RWIDTH-1:0] w_cs_low;
  logic              w_one_cs;
  logic              w_multi_cs;
  logic              w_sel;
  logic [RIW-1:0]    w_rank;
  logic [IW-1:0]     w_bidx;
  ddr4_cmd_e         w_cmd;
  logic              w_rdwr;

  logic [NB-1:0]     w_open, w_hit, w_in_rank, w_trcd_ok, w_trp_ok;
  logic [AWIDTH-1:0] w_row [NB];
  logic [AWIDTH-1:0] w_tgt_row;
  logic              w_tgt_open, w_rank_busy, w_tgt_trcd, w_tgt_trp;
  logic [ERR_W-1:0]  w_err_set;

  logic              r_cmd_vld;
  ddr4_cmd_e         r_cmd_type;
  logic [RIW-1:0]    r_cmd_rank;
  logic [GB-1:0]     r_cmd_bank;
  logic [AWIDTH-1:0] r_cmd_row;
  logic [9:0]        r_cmd_col;
  logic [ERR_W-1:0]  r_err;
  logic [CWIDTH-1:0] r_act_cnt, r_rd_cnt, r_wr_cnt;

  assign w_cs_low   = ~ddr4_cs_n;
  assign w_one_cs   = ($countones(w_cs_low) == 1);
  assign w_multi_cs = ($countones(w_cs_low) > 1);
  assign w_sel      = w_one_cs && |(w_cs_low & ddr4_cke);

  always_comb begin
    w_rank = '0;
    for (int r = 0; r < RWIDTH; r++) begin
      if (w_cs_low[r]) w_rank = RIW'(r);
    end
  end

  assign w_bidx = IW'({w_rank, ddr4_bg, ddr4_ba});

  always_comb begin
    w_cmd = NONE;
    if (w_sel) begin
      if (!ddr4_act_n) begin
        w_cmd = ACT;
      end else begin
        case ({ddr4_addr[A_RAS], ddr4_addr[A_CAS], ddr4_addr[A_WE]})
          3'b000:  w_cmd = MRS;
          3'b001:  w_cmd = REF;
          3'b010:  w_cmd = ddr4_addr[A_AP] ? PREA : PRE;
          3'b011:  w_cmd = RFU;
          3'b100:  w_cmd = ddr4_addr[A_AP] ? WRA : WR;
          3'b101:  w_cmd = ddr4_addr[A_AP] ? RDA : RD;
          3'b110:  w_cmd = ZQC;
          default: w_cmd = NONE;
        endcase
      end
    end
  end

  assign w_rdwr = is_rdwr(w_cmd);

  for (genvar g = 0; g < NB; g++) begin : g_bank
    assign w_hit[g]     = (w_bidx == IW'(g));
    assign w_in_rank[g] = (w_rank == RIW'(g / NBR));

    ddr4_bank_tracker #(
      .AWIDTH (AWIDTH),
      .TRCD   (TRCD),
      .TRP    (TRP)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_act      ((w_cmd == ACT) && w_hit[g]),
      .i_pre      (((w_cmd == PRE) && w_hit[g]) || ((w_cmd == PREA) && w_in_rank[g])),
      .i_ap_close (((w_cmd == RDA) || (w_cmd == WRA)) && w_hit[g]),
      .i_row      (ddr4_addr),
      .o_open     (w_open[g]),
      .o_row      (w_row[g]),
      .o_trcd_ok  (w_trcd_ok[g]),
      .o_trp_ok   (w_trp_ok[g])
    );
  end

  always_comb begin
    w_tgt_row = '0;
    for (int g = 0; g < NB; g++) begin
      if (w_hit[g]) w_tgt_row = w_row[g];
    end
  end

  assign w_tgt_open  = |(w_open & w_hit);
  assign w_rank_busy = |(w_open & w_in_rank);
  assign w_tgt_trcd  = |(w_trcd_ok & w_hit);
  assign w_tgt_trp   = |(w_trp_ok & w_hit);

  always_comb begin
    w_err_set               = '0;
    w_err_set[ERR_ACT_OPEN] = (w_cmd == ACT) && w_tgt_open;
    w_err_set[ERR_CLOSED]   = w_rdwr && !w_tgt_open;
    w_err_set[ERR_REF_OPEN] = ((w_cmd == REF) || (w_cmd == MRS)) && w_rank_busy;
    w_err_set[ERR_MULTI_CS] = w_multi_cs;
    w_err_set[ERR_TRCD]     = TIMING && w_rdwr && w_tgt_open && !w_tgt_trcd;
    w_err_set[ERR_TRP]      = TIMING && (w_cmd == ACT) && !w_tgt_open && !w_tgt_trp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_vld  <= 1'b0;
      r_cmd_type <= NONE;
      r_cmd_rank <= '0;
      r_cmd_bank <= '0;
      r_cmd_row  <= '0;
      r_cmd_col  <= '0;
      r_err      <= '0;
      r_act_cnt  <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_cmd_vld  <= (w_cmd != NONE);
      r_cmd_type <= w_cmd;
      r_cmd_rank <= (w_cmd != NONE) ? w_rank : '0;
      r_cmd_bank <= (w_cmd != NONE) ? {ddr4_bg, ddr4_ba} : '0;
      if (w_cmd == ACT)   r_cmd_row <= ddr4_addr;
      else if (w_rdwr)    r_cmd_row <= w_tgt_open ? w_tgt_row : '0;
      else                r_cmd_row <= '0;
      r_cmd_col  <= w_rdwr ? ddr4_addr[9:0] : '0;

      // clr takes priority over any command in the same slot.
      if (clr) begin
        r_err     <= '0;
        r_act_cnt <= '0;
        r_rd_cnt  <= '0;
        r_wr_cnt  <= '0;
      end else begin
        r_err <= r_err | w_err_set;
        if ((w_cmd == ACT) && (r_act_cnt != '1))                  r_act_cnt <= r_act_cnt + 1'b1;
        if (((w_cmd == RD) || (w_cmd == RDA)) && (r_rd_cnt != '1)) r_rd_cnt  <= r_rd_cnt + 1'b1;
        if (((w_cmd == WR) || (w_cmd == WRA)) && (r_wr_cnt != '1)) r_wr_cnt  <= r_wr_cnt + 1'b1;
      end
    end
  end

  assign cmd_vld   = r_cmd_vld;
  assign cmd_type  = r_cmd_type;
  assign cmd_rank  = r_cmd_rank;
  assign cmd_bank  = r_cmd_bank;
  assign cmd_row   = r_cmd_row;
  assign cmd_col   = r_cmd_col;
  assign bank_open = w_open;
  assign err       = r_err;
  assign act_cnt   = r_act_cnt;
  assign rd_cnt    = r_rd_cnt;
  assign wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_ddr4_cmd_tracker.sv
// Directed bench for ddr4_cmd_tracker (2 ranks, 4-bit counters, TRCD=TRP=16);
// expectations are hand-computed, timing ones depend on DDR4_CMD_TRACKER_TIMING_EN.
module tb_ddr4_cmd_tracker;

`ifdef DDR4_CMD_TRACKER_TIMING_EN
  localparam bit TIMING = 1'b1;
`else
  localparam bit TIMING = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ddr4_cke = 2'b11;
  logic [1:0]  ddr4_cs_n = 2'b11;
  logic        ddr4_act_n = 1'b1;
  logic [1:0]  ddr4_bg = '0;
  logic [1:0]  ddr4_ba = '0;
  logic [16:0] ddr4_addr = '0;
  logic        clr = 1'b0;
  logic        cmd_vld;
  logic [3:0]  cmd_type;
  logic [0:0]  cmd_rank;
  logic [3:0]  cmd_bank;
  logic [16:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [31:0] bank_open;
  logic [5:0]  err;
  logic [3:0]  act_cnt, rd_cnt, wr_cnt;

  int n_chk = 0;
  int n_err = 0;

  ddr4_cmd_tracker #(
    .AWIDTH(17), .RWIDTH(2), .BWIDTH(2), .GWIDTH(2), .CWIDTH(4), .TRCD(16), .TRP(16)
  ) dut (
    .clk(clk), .rst(rst), .ddr4_cke(ddr4_cke), .ddr4_cs_n(ddr4_cs_n), .ddr4_act_n(ddr4_act_n),
    .ddr4_bg(ddr4_bg), .ddr4_ba(ddr4_ba), .ddr4_addr(ddr4_addr), .clr(clr),
    .cmd_vld(cmd_vld), .cmd_type(cmd_type), .cmd_rank(cmd_rank), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .bank_open(bank_open), .err(err),
    .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command slot: pins set on negedge, sampled on posedge, outputs readable at +1.
  task automatic drive(input logic [1:0] cs_n, input logic act_n, input logic [1:0] bg,
                       input logic [1:0] ba, input logic [16:0] addr, input logic clr_i);
    @(negedge clk);
    ddr4_cs_n = cs_n; ddr4_act_n = act_n; ddr4_bg = bg; ddr4_ba = ba;
    ddr4_addr = addr; clr = clr_i;
    @(posedge clk);
    #1;
    ddr4_cs_n = 2'b11; ddr4_act_n = 1'b1; ddr4_addr = '0; clr = 1'b0;
  endtask

  task automatic act(input logic rank, input logic [1:0] bg, input logic [1:0] ba, input logic [16:0] row);
    drive(rank ? 2'b01 : 2'b10, 1'b0, bg, ba, row, 1'b0);
  endtask

  task automatic cmd(input logic rank, input logic [2:0] rcw, input logic ap,
                     input logic [1:0] bg, input logic [1:0] ba, input logic [9:0] col);
    drive(rank ? 2'b01 : 2'b10, 1'b1, bg, ba, {rcw, 3'b000, ap, col}, 1'b0);
  endtask

  task automatic do_clr();
    drive(2'b11, 1'b1, 2'd0, 2'd0, 17'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_vld", cmd_vld, 0);
    check("rst_err", err, 0);
    check("rst_open", bank_open, 0);
    check("rst_act_cnt", act_cnt, 0);
    check("rst_row", cmd_row, 0);
    @(negedge clk); rst = 1'b1;

    act(0, 2'd1, 2'd2, 17'h1234);
    check("act_vld", cmd_vld, 1);
    check("act_type", cmd_type, 5);
    check("act_row", cmd_row, 17'h1234);
    check("act_bank", cmd_bank, 6);
    check("act_open", bank_open, 32'h40);
    check("act_cnt1", act_cnt, 1);
    idle(1);
    check("vld_pulse", cmd_vld, 0);
    idle(15);
    cmd(0, 3'b101, 0, 2'd1, 2'd2, 10'h3F);
    check("rd_type", cmd_type, 8);
    check("rd_row", cmd_row, 17'h1234);
    check("rd_col", cmd_col, 10'h3F);
    check("rd_cnt1", rd_cnt, 1);
    check("rd_err", err, 0);
    cmd(0, 3'b101, 1, 2'd1, 2'd2, 10'h3F);
    check("rda_type", cmd_type, 9);
    check("rda_row", cmd_row, 17'h1234);
    check("rda_open", bank_open, 0);
    check("rda_cnt", rd_cnt, 2);

    cmd(0, 3'b101, 0, 2'd0, 2'd0, 10'h10);
    check("rd_closed_err", err, 6'h02);
    check("rd_closed_row", cmd_row, 0);
    check("rd_closed_cnt", rd_cnt, 3);
    act(0, 2'd0, 2'd0, 17'h0AA);
    check("act0_open", bank_open, 32'h1);
    act(0, 2'd0, 2'd0, 17'h0BB);
    check("act_twice_err", err, 6'h03);
    check("act_twice_cnt", act_cnt, 3);
    check("act_twice_row", cmd_row, 17'h0BB);
    do_clr();
    check("clr_err", err, 0);
    check("clr_act_cnt", act_cnt, 0);
    check("clr_rd_cnt", rd_cnt, 0);
    check("clr_open", bank_open, 32'h1);
    drive(2'b10, 1'b0, 2'd1, 2'd1, 17'h0CC, 1'b1);
    check("clr_act_vld", cmd_vld, 1);
    check("clr_act_cnt0", act_cnt, 0);
    check("clr_act_open", bank_open, 32'h21);
    idle(16);
    cmd(0, 3'b101, 0, 2'd0, 2'd0, 10'h1);
    check("row_overwrite", cmd_row, 17'h0BB);
    check("rd_after_clr", rd_cnt, 1);
    check("err_after_clr", err, 0);

    drive(2'b00, 1'b0, 2'd0, 2'd1, 17'h77, 1'b0);
    check("multi_vld", cmd_vld, 0);
    check("multi_err", err, 6'h08);
    check("multi_cnt", act_cnt, 0);
    check("multi_open", bank_open, 32'h21);
    ddr4_cke = 2'b10;
    act(0, 2'd0, 2'd2, 17'h5);
    check("cke_vld", cmd_vld, 0);
    check("cke_open", bank_open, 32'h21);
    ddr4_cke = 2'b11;
    act(1, 2'd0, 2'd0, 17'h55);
    check("r1_rank", cmd_rank, 1);
    check("r1_open", bank_open, 32'h0001_0021);
    act(1, 2'd3, 2'd3, 17'h66);
    check("r1_open2", bank_open, 32'h8001_0021);
    check("r1_cnt", act_cnt, 2);
    cmd(1, 3'b010, 1, 2'd0, 2'd0, 10'h0);
    check("prea_type", cmd_type, 4);
    check("prea_open", bank_open, 32'h21);
    cmd(1, 3'b110, 0, 2'd0, 2'd0, 10'h0);
    check("zqc_type", cmd_type, 10);
    do_clr();
    cmd(1, 3'b001, 0, 2'd0, 2'd0, 10'h0);
    check("ref_r1_type", cmd_type, 2);
    check("ref_r1_err", err, 0);
    cmd(0, 3'b001, 0, 2'd0, 2'd0, 10'h0);
    check("ref_r0_err", err, 6'h04);

    do_clr();
    for (int i = 0; i < 17; i++) cmd(0, 3'b100, 0, 2'd0, 2'd0, 10'(i));
    check("wr_sat", wr_cnt, 15);
    check("wr_type", cmd_type, 6);
    check("wr_col", cmd_col, 16);
    @(negedge clk);
    ddr4_cs_n = 2'b10; ddr4_addr = 17'h10000;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_vld", cmd_vld, 0);
    check("arst_wr", wr_cnt, 0);
    check("arst_open", bank_open, 0);
    check("arst_type", cmd_type, 0);
    ddr4_cs_n = 2'b11; ddr4_addr = '0;
    @(negedge clk); rst = 1'b1;

    act(0, 2'd0, 2'd0, 17'h1);
    check("t_act_err", err, 0);
    idle(4);
    cmd(0, 3'b101, 0, 2'd0, 2'd0, 10'h2);
    check("trcd_short", err, TIMING ? 32'h10 : 32'h0);
    do_clr();
    cmd(0, 3'b010, 0, 2'd0, 2'd0, 10'h0);
    check("pre_open", bank_open, 0);
    idle(16);
    act(0, 2'd0, 2'd0, 17'h2);
    check("trp_ok", err, 0);
    idle(15);
    cmd(0, 3'b101, 0, 2'd0, 2'd0, 10'h3);
    check("trcd_ok", err, 0);
    check("trcd_row", cmd_row, 17'h2);
    cmd(0, 3'b010, 0, 2'd0, 2'd0, 10'h0);
    idle(2);
    act(0, 2'd0, 2'd0, 17'h3);
    check("trp_short", err, TIMING ? 32'h20 : 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
